// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU/APB to single-port SRAM arbiter.
package cpu_mem_pkg;

   localparam int unsigned SRAM_DW = 32;
   localparam int unsigned SEL_W   = SRAM_DW / 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned STAT_W  = 16;

   typedef enum logic [1:0] {A_IDLE, A_WAIT, A_DATA} apb_state_e;
   typedef enum logic [1:0] {G_NONE, G_IMEM, G_DMEM, G_APB} grant_e;

   // Expand byte-lane enables into a per-bit mask (1 = lane written).
   function automatic logic [SRAM_DW-1:0] sel_to_mask(input logic [SEL_W-1:0] sel);
      logic [SRAM_DW-1:0] m;
      m = '0;
      for (int i = 0; i < int'(SEL_W); i++) m[i*8 +: 8] = {8{sel[i]}};
      return m;
   endfunction

endpackage

// File: rtl/cpu_mem_starve_cnt.sv
// Per-requester starvation counter; flags when a waiting request must be forced through.
module cpu_mem_starve_cnt
   import cpu_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req,
   input  logic i_gnt,
   output logic o_sat
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!i_req || i_gnt) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_W'(STARVE_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_sat = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/cpu_mem_arb.sv
// Arbitrates one single-port SRAM between CPU imem, CPU dmem and an APB slave port.
// Define CPU_MEM_ARB_STATS_EN to add conflict / forced-grant statistics counters.
module cpu_mem_arb
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_imem_stb,
   output logic                 o_imem_stall,
   output logic                 o_imem_ack,
   input  logic [31:0]          i_imem_addr,
   output logic [31:0]          o_imem_rdata,
   input  logic                 i_dmem_stb,
   output logic                 o_dmem_stall,
   output logic                 o_dmem_ack,
   input  logic                 i_dmem_we,
   input  logic [31:0]          i_dmem_addr,
   input  logic [3:0]           i_dmem_sel,
   input  logic [31:0]          i_dmem_wdata,
   output logic [31:0]          o_dmem_rdata,
   input  logic                 i_psel,
   input  logic                 i_penable,
   input  logic                 i_pwrite,
   input  logic [31:0]          i_paddr,
   input  logic [31:0]          i_pwdata,
   output logic                 o_pready,
   output logic [31:0]          o_prdata,
   output logic                 o_sram_cen,
   output logic                 o_sram_gwen,
   output logic [31:0]          o_sram_wen,
   output logic [ADDR_W-1:0]    o_sram_a,
   output logic [31:0]          o_sram_d,
`ifdef CPU_MEM_ARB_STATS_EN
   output logic [15:0]          o_stat_conflict,
   output logic [15:0]          o_stat_starve,
   input  logic                 i_stat_clr,
`endif
   input  logic [31:0]          i_sram_q
);

   apb_state_e r_apb_state;
   grant_e     w_gnt;
   logic       w_apb_req;
   logic       w_apb_sat;
   logic       w_dmem_sat;
   logic       w_forced;
   logic       r_imem_ack;
   logic       r_dmem_ack;
   logic       r_pready;
   logic       w_unused;

   assign w_apb_req = i_psel & i_penable & (r_apb_state != A_DATA);

   // Forced grants are gated by a live request so a stale count never wins.
   always_comb begin
      w_gnt    = G_NONE;
      w_forced = 1'b0;
      if (!i_rst_n) begin
         w_gnt = G_NONE;
      end else if (w_apb_req && w_apb_sat) begin
         w_gnt    = G_APB;
         w_forced = 1'b1;
      end else if (i_dmem_stb && w_dmem_sat) begin
         w_gnt    = G_DMEM;
         w_forced = 1'b1;
      end else if (i_imem_stb) begin
         w_gnt = G_IMEM;
      end else if (i_dmem_stb) begin
         w_gnt = G_DMEM;
      end else if (w_apb_req) begin
         w_gnt = G_APB;
      end
   end

   // Idle a/d follow imem address / dmem wdata to limit toggling.
   always_comb begin
      o_sram_cen  = 1'b1;
      o_sram_gwen = 1'b1;
      o_sram_wen  = '1;
      o_sram_a    = i_imem_addr[ADDR_W+1:2];
      o_sram_d    = i_dmem_wdata;
      case (w_gnt)
         G_IMEM: begin
            o_sram_cen = 1'b0;
         end
         G_DMEM: begin
            o_sram_cen  = 1'b0;
            o_sram_gwen = ~i_dmem_we;
            o_sram_wen  = i_dmem_we ? ~sel_to_mask(i_dmem_sel) : '1;
            o_sram_a    = i_dmem_addr[ADDR_W+1:2];
         end
         G_APB: begin
            o_sram_cen  = 1'b0;
            o_sram_gwen = ~i_pwrite;
            o_sram_wen  = {SRAM_DW{~i_pwrite}};
            o_sram_a    = i_paddr[ADDR_W+1:2];
            o_sram_d    = i_pwdata;
         end
         default: ;
      endcase
   end

   cpu_mem_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_dmem_starve (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (i_dmem_stb),
      .i_gnt   (w_gnt == G_DMEM),
      .o_sat   (w_dmem_sat)
   );

   cpu_mem_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_apb_starve (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (w_apb_req),
      .i_gnt   (w_gnt == G_APB),
      .o_sat   (w_apb_sat)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_imem_ack <= 1'b0;
         r_dmem_ack <= 1'b0;
      end else begin
         r_imem_ack <= (w_gnt == G_IMEM);
         r_dmem_ack <= (w_gnt == G_DMEM);
      end
   end

   // APB handshake: wait for a grant, then one pready cycle while Q is valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_apb_state <= A_IDLE;
         r_pready    <= 1'b0;
      end else begin
         r_pready <= 1'b0;
         case (r_apb_state)
            A_IDLE: begin
               if (w_apb_req) begin
                  if (w_gnt == G_APB) begin
                     r_apb_state <= A_DATA;
                     r_pready    <= 1'b1;
                  end else begin
                     r_apb_state <= A_WAIT;
                  end
               end
            end
            A_WAIT: begin
               if (w_gnt == G_APB) begin
                  r_apb_state <= A_DATA;
                  r_pready    <= 1'b1;
               end else if (!(i_psel && i_penable)) begin
                  r_apb_state <= A_IDLE;
               end
            end
            A_DATA:  r_apb_state <= A_IDLE;
            default: r_apb_state <= A_IDLE;
         endcase
      end
   end

`ifdef CPU_MEM_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat_conflict;
   logic [STAT_W-1:0] r_stat_starve;
   logic [1:0]        w_nreq;

   assign w_nreq = 2'(i_imem_stb) + 2'(i_dmem_stb) + 2'(w_apb_req);

   // Saturating statistics; a clear beats a same-cycle increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat_conflict <= '0;
         r_stat_starve   <= '0;
      end else if (i_stat_clr) begin
         r_stat_conflict <= '0;
         r_stat_starve   <= '0;
      end else begin
         if (w_nreq >= 2'd2 && r_stat_conflict != '1)
            r_stat_conflict <= r_stat_conflict + STAT_W'(1);
         if (w_forced && r_stat_starve != '1)
            r_stat_starve <= r_stat_starve + STAT_W'(1);
      end
   end

   assign o_stat_conflict = r_stat_conflict;
   assign o_stat_starve   = r_stat_starve;
`endif

   assign o_imem_stall = i_imem_stb & (w_gnt != G_IMEM);
   assign o_dmem_stall = i_dmem_stb & (w_gnt != G_DMEM);
   assign o_imem_ack   = r_imem_ack;
   assign o_dmem_ack   = r_dmem_ack;
   assign o_pready     = r_pready;
   assign o_imem_rdata = i_sram_q;
   assign o_dmem_rdata = i_sram_q;
   assign o_prdata     = i_sram_q;

   assign w_unused = &{1'b0, w_forced,
                       i_imem_addr[31:ADDR_W+2], i_imem_addr[1:0],
                       i_dmem_addr[31:ADDR_W+2], i_dmem_addr[1:0],
                       i_paddr[31:ADDR_W+2], i_paddr[1:0]};

endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed bench for cpu_mem_arb with a behavioural single-port SRAM model.
module tb_cpu_mem_arb;

   localparam int unsigned ADDR_W     = 14;
   localparam int unsigned STARVE_MAX = 4;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_imem_stb, o_imem_stall, o_imem_ack;
   logic [31:0]       i_imem_addr, o_imem_rdata;
   logic              i_dmem_stb, o_dmem_stall, o_dmem_ack, i_dmem_we;
   logic [31:0]       i_dmem_addr, i_dmem_wdata, o_dmem_rdata;
   logic [3:0]        i_dmem_sel;
   logic              i_psel, i_penable, i_pwrite, o_pready;
   logic [31:0]       i_paddr, i_pwdata, o_prdata;
   logic              o_sram_cen, o_sram_gwen;
   logic [31:0]       o_sram_wen, o_sram_d, i_sram_q;
   logic [ADDR_W-1:0] o_sram_a;
`ifdef CPU_MEM_ARB_STATS_EN
   logic [15:0]       o_stat_conflict, o_stat_starve;
   logic              i_stat_clr = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   cpu_mem_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_imem_stb(i_imem_stb), .o_imem_stall(o_imem_stall), .o_imem_ack(o_imem_ack),
      .i_imem_addr(i_imem_addr), .o_imem_rdata(o_imem_rdata),
      .i_dmem_stb(i_dmem_stb), .o_dmem_stall(o_dmem_stall), .o_dmem_ack(o_dmem_ack),
      .i_dmem_we(i_dmem_we), .i_dmem_addr(i_dmem_addr), .i_dmem_sel(i_dmem_sel),
      .i_dmem_wdata(i_dmem_wdata), .o_dmem_rdata(o_dmem_rdata),
      .i_psel(i_psel), .i_penable(i_penable), .i_pwrite(i_pwrite),
      .i_paddr(i_paddr), .i_pwdata(i_pwdata), .o_pready(o_pready), .o_prdata(o_prdata),
      .o_sram_cen(o_sram_cen), .o_sram_gwen(o_sram_gwen), .o_sram_wen(o_sram_wen),
      .o_sram_a(o_sram_a), .o_sram_d(o_sram_d),
`ifdef CPU_MEM_ARB_STATS_EN
      .o_stat_conflict(o_stat_conflict), .o_stat_starve(o_stat_starve),
      .i_stat_clr(i_stat_clr),
`endif
      .i_sram_q(i_sram_q)
   );

   // SRAM model: bit-masked write when gwen low, registered read otherwise.
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   always_ff @(posedge i_clk) begin
      if (!o_sram_cen) begin
         if (!o_sram_gwen) mem[o_sram_a] <= (mem[o_sram_a] & o_sram_wen) | (o_sram_d & ~o_sram_wen);
         else              i_sram_q <= mem[o_sram_a];
      end
   end

   task automatic idle_all();
      i_imem_stb = 1'b0; i_dmem_stb = 1'b0; i_dmem_we = 1'b0;
      i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
   endtask

   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int ncyc, output logic [31:0] rdata);
      bit done;
      done = 1'b0; ncyc = 0; rdata = '0;
      @(negedge i_clk);
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = addr; i_pwdata = wdata;
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge i_clk);
         i_penable = 1'b1;
         #1;
         if (o_pready) begin ncyc = k; rdata = o_prdata; done = 1'b1; end
      end
      if (!done) $display("FAIL apb_timeout: pready never seen within 20 cycles");
      @(negedge i_clk);
      i_psel = 1'b0; i_penable = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      i_rst_n = 1'b0;
      i_imem_stb = 1'b1; i_imem_addr = 32'h40;
      repeat (2) @(negedge i_clk);
      #1;
      n_checks++; if (o_imem_ack !== 1'b0) begin n_errors++; $display("FAIL reset_imem_ack: got %b want 0", o_imem_ack); end
      n_checks++; if (o_dmem_ack !== 1'b0) begin n_errors++; $display("FAIL reset_dmem_ack: got %b want 0", o_dmem_ack); end
      n_checks++; if (o_pready !== 1'b0) begin n_errors++; $display("FAIL reset_pready: got %b want 0", o_pready); end
      n_checks++; if (o_sram_cen !== 1'b1) begin n_errors++; $display("FAIL reset_cen: got %b want 1", o_sram_cen); end
      @(negedge i_clk);
      idle_all();
      i_rst_n = 1'b1;
   endtask

   task automatic test_dmem_write();
      @(negedge i_clk);
      i_dmem_stb = 1'b1; i_dmem_we = 1'b1; i_dmem_addr = 32'h40; i_dmem_sel = 4'hF; i_dmem_wdata = 32'h11223344;
      #1;
      n_checks++; if (o_sram_cen !== 1'b0 || o_sram_gwen !== 1'b0 || o_sram_wen !== 32'h0)
         begin n_errors++; $display("FAIL dw_full: cen=%b gwen=%b wen=%h want 0 0 00000000", o_sram_cen, o_sram_gwen, o_sram_wen); end
      n_checks++; if (o_sram_a !== 14'h10) begin n_errors++; $display("FAIL dw_addr: got %h want 0010", o_sram_a); end
      @(negedge i_clk);
      i_dmem_sel = 4'b0101; i_dmem_wdata = 32'hAABBCCDD;
      #1;
      n_checks++; if (o_sram_wen !== 32'hFF00FF00) begin n_errors++; $display("FAIL dw_wen: got %h want ff00ff00", o_sram_wen); end
      n_checks++; if (o_sram_gwen !== 1'b0 || o_sram_d !== 32'hAABBCCDD)
         begin n_errors++; $display("FAIL dw_drive: gwen=%b d=%h want 0 aabbccdd", o_sram_gwen, o_sram_d); end
      n_checks++; if (o_dmem_stall !== 1'b0) begin n_errors++; $display("FAIL dw_stall: got %b want 0", o_dmem_stall); end
      n_checks++; if (o_dmem_ack !== 1'b1) begin n_errors++; $display("FAIL dw_ack1: got %b want 1", o_dmem_ack); end
      @(negedge i_clk);
      idle_all();
      #1;
      n_checks++; if (o_dmem_ack !== 1'b1) begin n_errors++; $display("FAIL dw_ack2: got %b want 1", o_dmem_ack); end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_dmem_ack !== 1'b0) begin n_errors++; $display("FAIL dw_ack_drop: got %b want 0", o_dmem_ack); end
   endtask

   task automatic test_imem_read();
      @(negedge i_clk);
      i_imem_stb = 1'b1; i_imem_addr = 32'h40;
      #1;
      n_checks++; if (o_sram_a !== 14'h10 || o_sram_cen !== 1'b0 || o_sram_gwen !== 1'b1)
         begin n_errors++; $display("FAIL ir_drive: a=%h cen=%b gwen=%b want 0010 0 1", o_sram_a, o_sram_cen, o_sram_gwen); end
      n_checks++; if (o_imem_stall !== 1'b0) begin n_errors++; $display("FAIL ir_stall: got %b want 0", o_imem_stall); end
      @(negedge i_clk);
      i_imem_stb = 1'b0;
      #1;
      n_checks++; if (o_imem_ack !== 1'b1) begin n_errors++; $display("FAIL ir_ack: got %b want 1", o_imem_ack); end
      n_checks++; if (o_imem_rdata !== 32'h11BB33DD) begin n_errors++; $display("FAIL ir_rdata: got %h want 11bb33dd", o_imem_rdata); end
      n_checks++; if (o_sram_cen !== 1'b1) begin n_errors++; $display("FAIL ir_cen_idle: got %b want 1", o_sram_cen); end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_imem_ack !== 1'b0) begin n_errors++; $display("FAIL ir_ack_drop: got %b want 0", o_imem_ack); end
   endtask

   task automatic test_dmem_starve();
      @(negedge i_clk);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge i_clk);
         i_imem_stb = 1'b1; i_imem_addr = 32'h40;
         i_dmem_stb = 1'b1; i_dmem_we = 1'b0; i_dmem_addr = 32'h300;
         #1;
         n_checks++; if (o_dmem_stall !== (c < 5)) begin n_errors++; $display("FAIL starve_dstall c%0d: got %b want %b", c, o_dmem_stall, c < 5); end
         n_checks++; if (o_imem_stall !== (c == 5)) begin n_errors++; $display("FAIL starve_istall c%0d: got %b want %b", c, o_imem_stall, c == 5); end
      end
      n_checks++; if (o_sram_a !== 14'hC0) begin n_errors++; $display("FAIL starve_addr: got %h want 00c0", o_sram_a); end
      @(negedge i_clk);
      idle_all();
      #1;
      n_checks++; if (o_dmem_ack !== 1'b1) begin n_errors++; $display("FAIL starve_dack: got %b want 1", o_dmem_ack); end
      @(negedge i_clk);
   endtask

   task automatic test_apb();
      int n; logic [31:0] rd;
      apb_xfer(1'b1, 32'h100, 32'hCAFEF00D, n, rd);
      n_checks++; if (n !== 2) begin n_errors++; $display("FAIL apb_wr_latency: got %0d want 2", n); end
      apb_xfer(1'b0, 32'h100, 32'h0, n, rd);
      n_checks++; if (n !== 2) begin n_errors++; $display("FAIL apb_rd_latency: got %0d want 2", n); end
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL apb_rd_data: got %h want cafef00d", rd); end
      // CPU saturating the SRAM: APB forced through on the 5th penable cycle
      @(negedge i_clk);
      i_imem_stb = 1'b1; i_imem_addr = 32'h40;
      i_dmem_stb = 1'b1; i_dmem_we = 1'b0; i_dmem_addr = 32'h300;
      apb_xfer(1'b0, 32'h100, 32'h0, n, rd);
      n_checks++; if (n !== STARVE_MAX + 2) begin n_errors++; $display("FAIL apb_contended_latency: got %0d want %0d", n, STARVE_MAX + 2); end
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL apb_contended_data: got %h want cafef00d", rd); end
      @(negedge i_clk);
      idle_all();
      @(negedge i_clk);
   endtask

   task automatic test_all_saturated();
      @(negedge i_clk);
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = 32'h100;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         i_penable = 1'b1;
         i_imem_stb = 1'b1; i_imem_addr = 32'h200;
         i_dmem_stb = 1'b1; i_dmem_we = 1'b0; i_dmem_addr = 32'h300;
         #1;
         n_checks++; if (o_imem_stall !== 1'b0 || o_dmem_stall !== 1'b1)
            begin n_errors++; $display("FAIL sat_build c%0d: istall=%b dstall=%b want 0 1", c, o_imem_stall, o_dmem_stall); end
      end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_sram_a !== 14'h40 || o_imem_stall !== 1'b1 || o_dmem_stall !== 1'b1)
         begin n_errors++; $display("FAIL sat_apb_wins: a=%h istall=%b dstall=%b want 0040 1 1", o_sram_a, o_imem_stall, o_dmem_stall); end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_pready !== 1'b1 || o_prdata !== 32'hCAFEF00D)
         begin n_errors++; $display("FAIL sat_pready: pready=%b prdata=%h want 1 cafef00d", o_pready, o_prdata); end
      n_checks++; if (o_sram_a !== 14'hC0 || o_dmem_stall !== 1'b0 || o_imem_stall !== 1'b1)
         begin n_errors++; $display("FAIL sat_dmem_next: a=%h dstall=%b istall=%b want 00c0 0 1", o_sram_a, o_dmem_stall, o_imem_stall); end
      @(negedge i_clk);
      i_psel = 1'b0; i_penable = 1'b0;
      #1;
      n_checks++; if (o_sram_a !== 14'h80 || o_imem_stall !== 1'b0 || o_dmem_stall !== 1'b1)
         begin n_errors++; $display("FAIL sat_imem_last: a=%h istall=%b dstall=%b want 0080 0 1", o_sram_a, o_imem_stall, o_dmem_stall); end
      n_checks++; if (o_pready !== 1'b0) begin n_errors++; $display("FAIL sat_pready_drop: got %b want 0", o_pready); end
      @(negedge i_clk);
      idle_all();
      @(negedge i_clk);
   endtask

   task automatic test_back_to_back();
      @(negedge i_clk);
      i_imem_stb = 1'b1; i_imem_addr = 32'h40;
      #1;
      n_checks++; if (o_imem_stall !== 1'b0 || o_sram_a !== 14'h10)
         begin n_errors++; $display("FAIL b2b_0: stall=%b a=%h want 0 0010", o_imem_stall, o_sram_a); end
      @(negedge i_clk);
      i_imem_addr = 32'h100;
      #1;
      n_checks++; if (o_imem_ack !== 1'b1 || o_imem_rdata !== 32'h11BB33DD || o_imem_stall !== 1'b0 || o_sram_a !== 14'h40)
         begin n_errors++; $display("FAIL b2b_1: ack=%b rdata=%h stall=%b a=%h want 1 11bb33dd 0 0040", o_imem_ack, o_imem_rdata, o_imem_stall, o_sram_a); end
      @(negedge i_clk);
      i_imem_addr = 32'h40;
      #1;
      n_checks++; if (o_imem_ack !== 1'b1 || o_imem_rdata !== 32'hCAFEF00D || o_sram_a !== 14'h10)
         begin n_errors++; $display("FAIL b2b_2: ack=%b rdata=%h a=%h want 1 cafef00d 0010", o_imem_ack, o_imem_rdata, o_sram_a); end
      @(negedge i_clk);
      idle_all();
      #1;
      n_checks++; if (o_imem_ack !== 1'b1 || o_imem_rdata !== 32'h11BB33DD)
         begin n_errors++; $display("FAIL b2b_3: ack=%b rdata=%h want 1 11bb33dd", o_imem_ack, o_imem_rdata); end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_imem_ack !== 1'b0) begin n_errors++; $display("FAIL b2b_ack_drop: got %b want 0", o_imem_ack); end
   endtask

   task automatic test_reset_mid();
      // Build the dmem starvation count to 3, then reset right after an imem grant
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         i_imem_stb = 1'b1; i_imem_addr = 32'h40;
         i_dmem_stb = 1'b1; i_dmem_we = 1'b0; i_dmem_addr = 32'h300;
      end
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      n_checks++; if (o_imem_ack !== 1'b0 || o_dmem_ack !== 1'b0 || o_pready !== 1'b0)
         begin n_errors++; $display("FAIL rstmid_acks: iack=%b dack=%b pready=%b want 0 0 0", o_imem_ack, o_dmem_ack, o_pready); end
      n_checks++; if (o_sram_cen !== 1'b1) begin n_errors++; $display("FAIL rstmid_cen: got %b want 1", o_sram_cen); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      n_checks++; if (o_imem_stall !== 1'b0 || o_sram_cen !== 1'b0)
         begin n_errors++; $display("FAIL rstmid_first: istall=%b cen=%b want 0 0", o_imem_stall, o_sram_cen); end
      n_checks++; if (o_dmem_stall !== 1'b1) begin n_errors++; $display("FAIL rstmid_dstall c1: got %b want 1", o_dmem_stall); end
      for (int c = 2; c <= 5; c++) begin
         @(negedge i_clk);
         #1;
         n_checks++; if (o_dmem_stall !== (c < 5)) begin n_errors++; $display("FAIL rstmid_dstall c%0d: got %b want %b", c, o_dmem_stall, c < 5); end
      end
      @(negedge i_clk);
      idle_all();
      @(negedge i_clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_imem_addr = '0; i_dmem_addr = '0; i_dmem_sel = '0; i_dmem_wdata = '0;
      i_paddr = '0; i_pwdata = '0;
      test_reset();
      test_dmem_write();
      test_imem_read();
      test_dmem_starve();
      test_apb();
      test_all_saturated();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arb.md
Name: cpu_mem_arb

Overview:
- Arbitrates one single-port synchronous SRAM (one access per cycle, Q valid the cycle after CEN low) between three requesters.
- Requesters: CPU instruction port, CPU data port (both pipelined stb/stall/ack) and an APB slave port used for code load and debug.
- Default priority is imem > dmem > apb. Per-requester starvation counters guarantee forward progress for dmem and APB.
- Sits between the CPU core / APB bridge and the SRAM macro instance.

Parameters:
- ADDR_W, 14, SRAM word-address width; the byte address bits used are [ADDR_W+1:2].
- STARVE_MAX, 4, consecutive stalled cycles after which a waiting dmem or APB request is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_imem_stb  in  1  instruction request
- o_imem_stall  out  1  request not accepted this cycle
- o_imem_ack  out  1  read data valid
- i_imem_addr  in  32  byte address
- o_imem_rdata  out  32  read data
- i_dmem_stb  in  1  data request
- o_dmem_stall  out  1  request not accepted this cycle
- o_dmem_ack  out  1  access complete
- i_dmem_we  in  1  write enable
- i_dmem_addr  in  32  byte address
- i_dmem_sel  in  4  byte lane enables
- i_dmem_wdata  in  32  write data
- o_dmem_rdata  out  32  read data
- i_psel  in  1  APB select
- i_penable  in  1  APB enable
- i_pwrite  in  1  APB write
- i_paddr  in  32  APB byte address
- i_pwdata  in  32  APB write data
- o_pready  out  1  APB transfer complete
- o_prdata  out  32  APB read data
- o_sram_cen  out  1  chip enable, active low
- o_sram_gwen  out  1  global write enable, active low
- o_sram_wen  out  32  bit write mask, active low
- o_sram_a  out  ADDR_W  word address
- o_sram_d  out  32  write data
- i_sram_q  in  32  read data

Behaviour:
- Reset values: all acks 0, o_pready 0, both starvation counters 0, APB FSM in A_IDLE.
- Reset asserted mid-operation drops all in-flight acks and pready; no SRAM access is issued while reset is asserted (cen=1).
- Request definitions:
  - apb_req = i_psel & i_penable & state != A_DATA.
  - Requesters: imem_stb, dmem_stb, apb_req.
- Grant order, evaluated combinationally each cycle (first match wins):
  1. APB if apb_cnt == STARVE_MAX.
  2. dmem if dmem_cnt == STARVE_MAX.
  3. imem.
  4. dmem.
  5. APB.
- Exactly one grant or none per cycle.
- Stall outputs: o_imem_stall = imem_stb & ~gnt_imem; o_dmem_stall = dmem_stb & ~gnt_dmem.
- Counter update, per counter:
  - Cleared on its own grant.
  - Incremented, saturating at STARVE_MAX, when its request is present but not granted.
  - Cleared when its request is absent.
- SRAM drive for the granted requester, cen=0:
  - imem: gwen=1, wen all 1s.
  - dmem write: gwen=0, wen = ~byte-expanded i_dmem_sel.
  - dmem read: gwen=1, wen all 1s.
  - APB: gwen = ~i_pwrite, wen = {32{~i_pwrite}}.
  - a = addr[ADDR_W+1:2]; d = the granted requester's wdata.
- No grant: cen=1, gwen=1, wen all 1s; a and d hold the imem address / dmem wdata (don't-care, chosen to limit toggling).
- Acks: o_imem_ack and o_dmem_ack are registered, asserted exactly one cycle after the grant, for writes as well as reads.
- Read data: o_imem_rdata, o_dmem_rdata and o_prdata are all driven directly from i_sram_q (valid when the matching ack/pready is high).
- APB FSM:
  - A_IDLE: if apb_req and granted -> A_DATA; if apb_req and not granted -> A_WAIT.
  - A_WAIT: if granted -> A_DATA; if i_penable drops (protocol error) -> A_IDLE.
  - A_DATA: o_pready=1 for exactly one cycle, prdata = i_sram_q; then -> A_IDLE.
- APB minimum latency: setup cycle, then 2 cycles with penable high; pready is high in the second.
- Simultaneous requests with imem stb held every cycle: dmem is forced through on the (STARVE_MAX+1)th cycle; APB is also forced through, and APB forcing takes precedence over dmem forcing.
- Pipelined back-to-back imem requests are each granted in consecutive cycles, and each ack follows its grant by one cycle.

Optional Feature:
- CPU_MEM_ARB_STATS_EN defined:
  - Adds outputs o_stat_conflict (16 bit) and o_stat_starve (16 bit), plus input i_stat_clr.
  - o_stat_conflict counts cycles with ≥2 requests; o_stat_starve counts forced grants.
  - Both counters saturate at 16'hFFFF, reset to 0, and are cleared synchronously by i_stat_clr.
  - A clear in the same cycle as an increment wins (counter = 0).
- Macro undefined: these ports and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package cpu_mem_pkg:
  - typedef enum apb_state_e {A_IDLE, A_WAIT, A_DATA}
  - typedef enum grant_e {G_NONE, G_IMEM, G_DMEM, G_APB}
  - localparam SRAM_DW = 32
- Sub-module cpu_mem_starve_cnt (req, gnt -> saturated flag, STARVE_MAX parameter), instantiated twice (dmem, apb).

Test Plan:
- Single imem read, addr 0x40 -> o_sram_a=0x10, cen=0 for 1 cycle; ack the next cycle with rdata = Q.
- dmem write, sel=4'b0101, wdata 0xAABBCCDD -> wen=0xFF00FF00, gwen=0, ack 1 cycle later, no stall.
- imem stb held continuously plus dmem stb, STARVE_MAX=4 -> dmem_stall high for 4 cycles, granted in the 5th; imem_stall high only in that cycle.
- APB read of 0x100 with CPU idle -> pready high in the 2nd penable cycle with prdata = Q; with imem and dmem both saturating the SRAM, pready arrives within STARVE_MAX+2 penable cycles.
- All three request together with both counters saturated -> APB wins, then dmem, then imem.
- Reset asserted the cycle after an imem grant -> no ack, pready 0, counters 0; first request after reset is granted immediately.
